// File: rtl/register_bank_2r1w.sv
// Register file: 2^ADDR_W x DATA_W, two registered read ports, one write port, busy scoreboard.
// Reads land one cycle after re; same-cycle writes forward to the read ports and clear the hazard.
// No backpressure; every request is taken on the edge it is presented.
module register_bank_2r1w #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        write_addr,
  input  logic [DATA_W-1:0]        write_data,
  input  logic                     re,
  input  logic [ADDR_W-1:0]        read_addr_a,
  input  logic [ADDR_W-1:0]        read_addr_b,
  output logic [DATA_W-1:0]        read_data_a,
  output logic [DATA_W-1:0]        read_data_b,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     busy_a,
  output logic                     busy_b,
  output logic [(1<<ADDR_W)-1:0]   busy_vec
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_nxt;
  logic [DATA_W-1:0] rd_a_nxt;
  logic [DATA_W-1:0] rd_b_nxt;
  logic              wr_ok;
  logic              rsv_ok;

  // A write to the hardwired zero register is invisible everywhere, including forwarding.
  assign wr_ok  = we && !(ZERO_REG != 0 && write_addr == '0);
  assign rsv_ok = rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);

  function automatic logic [DATA_W-1:0] read_src(input logic [ADDR_W-1:0] a);
    if (ZERO_REG != 0 && a == '0)
      return '0;
    else if (wr_ok && write_addr == a)
      return write_data;
    else
      return regs[a];
  endfunction

  always_comb begin
    rd_a_nxt = read_src(read_addr_a);
    rd_b_nxt = read_src(read_addr_b);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (wr_ok) begin
      regs[write_addr] <= write_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data_a <= '0;
      read_data_b <= '0;
    end else if (re) begin
      read_data_a <= rd_a_nxt;
      read_data_b <= rd_b_nxt;
    end
  end

  // Reservation is applied after the write clear so a newer producer keeps the register busy.
  always_comb begin
    busy_nxt = busy_q;
    if (wr_ok)
      busy_nxt[write_addr] = 1'b0;
    if (rsv_ok)
      busy_nxt[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      busy_q <= '0;
    else
      busy_q <= busy_nxt;
  end

  assign busy_vec = busy_q;
  assign busy_a   = busy_q[read_addr_a] && !(wr_ok && write_addr == read_addr_a);
  assign busy_b   = busy_q[read_addr_b] && !(wr_ok && write_addr == read_addr_b);

endmodule

// File: tb/tb_register_bank_2r1w.sv
// Bench: 8x8 banks with and without the zero register share stimulus; a 16x16 bank covers the wide case.
module tb_register_bank_2r1w;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       we, re, rsv_en;
  logic [2:0] wa, raa, rab, rsa;
  logic [7:0] wd;

  logic [7:0] rda0, rdb0, bv0, rda1, rdb1, bv1;
  logic       ba0, bb0, ba1, bb1;

  logic        w_we, w_re, w_rsv;
  logic [3:0]  w_wa, w_raa, w_rab, w_rsa;
  logic [15:0] w_wd, rda2, rdb2, bv2;
  logic        ba2, bb2;

  int checks = 0;
  int failures = 0;

  register_bank_2r1w #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1)) dut0 (
    .clk(clk), .rst(rst), .we(we), .write_addr(wa), .write_data(wd), .re(re),
    .read_addr_a(raa), .read_addr_b(rab), .read_data_a(rda0), .read_data_b(rdb0),
    .rsv_en(rsv_en), .rsv_addr(rsa), .busy_a(ba0), .busy_b(bb0), .busy_vec(bv0));

  register_bank_2r1w #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0)) dut1 (
    .clk(clk), .rst(rst), .we(we), .write_addr(wa), .write_data(wd), .re(re),
    .read_addr_a(raa), .read_addr_b(rab), .read_data_a(rda1), .read_data_b(rdb1),
    .rsv_en(rsv_en), .rsv_addr(rsa), .busy_a(ba1), .busy_b(bb1), .busy_vec(bv1));

  register_bank_2r1w #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1)) dut2 (
    .clk(clk), .rst(rst), .we(w_we), .write_addr(w_wa), .write_data(w_wd), .re(w_re),
    .read_addr_a(w_raa), .read_addr_b(w_rab), .read_data_a(rda2), .read_data_b(rdb2),
    .rsv_en(w_rsv), .rsv_addr(w_rsa), .busy_a(ba2), .busy_b(bb2), .busy_vec(bv2));

  // Reference model; index 0 = zero-register bank, index 1 = ordinary bank.
  logic [7:0] m_mem  [2][8];
  logic [7:0] m_busy [2];
  logic [7:0] m_rda  [2];
  logic [7:0] m_rdb  [2];

  function automatic logic m_wok(int k);
    return we && !(k == 0 && wa == 3'd0);
  endfunction

  function automatic logic [7:0] m_read(int k, logic [2:0] a);
    if (k == 0 && a == 3'd0) return 8'h00;
    if (m_wok(k) && wa == a) return wd;
    return m_mem[k][a];
  endfunction

  function automatic logic m_bcomb(int k, logic [2:0] a);
    return m_busy[k][a] && !(m_wok(k) && wa == a);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) m_mem[k][i] = 8'h00;
      m_busy[k] = 8'h00;
      m_rda[k]  = 8'h00;
      m_rdb[k]  = 8'h00;
    end
  endtask

  // Advance one clock edge (starting and ending at negedge) and update the model.
  task automatic tick();
    for (int k = 0; k < 2; k++) begin
      if (re) begin
        m_rda[k] = m_read(k, raa);
        m_rdb[k] = m_read(k, rab);
      end
      for (int i = 0; i < 8; i++) begin
        if (rsv_en && rsa == 3'(i) && !(k == 0 && i == 0))
          m_busy[k][i] = 1'b1;
        else if (m_wok(k) && wa == 3'(i))
          m_busy[k][i] = 1'b0;
      end
      if (m_wok(k)) m_mem[k][wa] = wd;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    we = 1'b0; re = 1'b0; rsv_en = 1'b0;
    wa = 3'd0; wd = 8'h00; raa = 3'd0; rab = 3'd0; rsa = 3'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    we = 1'b1; wa = 3'd5; wd = 8'hAA; rsv_en = 1'b1; rsa = 3'd5; re = 1'b1; raa = 3'd5; rab = 3'd5;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rda0 !== 8'h00 || bv0 !== 8'h00) begin
      failures++;
      $display("FAIL reset_held: rda=%h bv=%h required 00 00", rda0, bv0);
    end
    rst = 1'b0;
    model_reset();
    we = 1'b0; rsv_en = 1'b0;
    tick();
    checks++;
    if (rda0 !== 8'h00 || rdb0 !== 8'h00 || bv0 !== 8'h00 || rda1 !== 8'h00 || bv1 !== 8'h00) begin
      failures++;
      $display("FAIL reset_read5: rda0=%h rdb0=%h bv0=%h rda1=%h bv1=%h required all 00",
               rda0, rdb0, bv0, rda1, bv1);
    end
    idle();
  endtask

  task automatic test_basic();
    we = 1'b1; wa = 3'd2; wd = 8'h3C;
    tick();
    we = 1'b0; re = 1'b1; raa = 3'd2; rab = 3'd2;
    tick();
    checks++;
    if (rda0 !== 8'h3C || rdb0 !== 8'h3C) begin
      failures++;
      $display("FAIL basic_read: a=%h b=%h required 3c 3c", rda0, rdb0);
    end
    re = 1'b0; raa = 3'd0; rab = 3'd1;
    tick();
    checks++;
    if (rda0 !== 8'h3C || rdb0 !== 8'h3C) begin
      failures++;
      $display("FAIL basic_hold: a=%h b=%h required 3c 3c", rda0, rdb0);
    end
    idle();
  endtask

  task automatic test_forward();
    we = 1'b1; wa = 3'd3; wd = 8'h11;
    tick();
    wa = 3'd4; wd = 8'h5A; re = 1'b1; raa = 3'd4; rab = 3'd3;
    tick();
    checks++;
    if (rda0 !== 8'h5A || rdb0 !== 8'h11) begin
      failures++;
      $display("FAIL forward: a=%h b=%h required 5a 11", rda0, rdb0);
    end
    we = 1'b0; raa = 3'd4;
    tick();
    checks++;
    if (rda0 !== 8'h5A) begin
      failures++;
      $display("FAIL forward_after: a=%h required 5a", rda0);
    end
    idle();
  endtask

  task automatic test_zero_reg();
    we = 1'b1; wa = 3'd0; wd = 8'hFF; rsv_en = 1'b1; rsa = 3'd0;
    tick();
    checks++;
    if (bv0[0] !== 1'b0 || bv1[0] !== 1'b1) begin
      failures++;
      $display("FAIL zero_busy: zr1=%b zr0=%b required 0 1", bv0[0], bv1[0]);
    end
    we = 1'b0; rsv_en = 1'b0; re = 1'b1; raa = 3'd0; rab = 3'd0;
    #1;
    checks++;
    if (ba0 !== 1'b0 || ba1 !== 1'b1) begin
      failures++;
      $display("FAIL zero_busy_a: zr1=%b zr0=%b required 0 1", ba0, ba1);
    end
    tick();
    checks++;
    if (rda0 !== 8'h00 || rda1 !== 8'hFF) begin
      failures++;
      $display("FAIL zero_read: zr1=%h zr0=%h required 00 ff", rda0, rda1);
    end
    idle();
  endtask

  task automatic test_scoreboard();
    rsv_en = 1'b1; rsa = 3'd6;
    tick();
    rsv_en = 1'b0; raa = 3'd6;
    #1;
    checks++;
    if (ba0 !== 1'b1 || bv0[6] !== 1'b1) begin
      failures++;
      $display("FAIL rsv_busy: busy_a=%b bv6=%b required 1 1", ba0, bv0[6]);
    end
    we = 1'b1; wa = 3'd6; wd = 8'h77;
    #1;
    checks++;
    if (ba0 !== 1'b0) begin
      failures++;
      $display("FAIL write_clears_busy_a: busy_a=%b required 0", ba0);
    end
    tick();
    checks++;
    if (bv0[6] !== 1'b0) begin
      failures++;
      $display("FAIL write_clears_bv: bv6=%b required 0", bv0[6]);
    end
    idle();
  endtask

  task automatic test_simultaneous();
    rsv_en = 1'b1; rsa = 3'd6; we = 1'b1; wa = 3'd6; wd = 8'h9C;
    tick();
    rsv_en = 1'b0; we = 1'b0; re = 1'b1; raa = 3'd6;
    #1;
    checks++;
    if (bv0[6] !== 1'b1 || ba0 !== 1'b1) begin
      failures++;
      $display("FAIL simul_busy: bv6=%b busy_a=%b required 1 1", bv0[6], ba0);
    end
    tick();
    checks++;
    if (rda0 !== 8'h9C) begin
      failures++;
      $display("FAIL simul_data: r6=%h required 9c", rda0);
    end
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      we     = 1'($urandom_range(0, 1));
      re     = 1'($urandom_range(0, 3) != 0);
      rsv_en = 1'($urandom_range(0, 2) == 0);
      wa     = 3'($urandom_range(0, 7));
      wd     = 8'($urandom);
      raa    = 3'($urandom_range(0, 7));
      rab    = ($urandom_range(0, 3) == 0) ? raa : 3'($urandom_range(0, 7));
      rsa    = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
      #1;
      for (int k = 0; k < 2; k++) begin
        logic oa, ob;
        oa = (k == 0) ? ba0 : ba1;
        ob = (k == 0) ? bb0 : bb1;
        checks++;
        if (oa !== m_bcomb(k, raa) || ob !== m_bcomb(k, rab)) begin
          failures++;
          $display("FAIL rand_busy_ab[%0d] n=%0d: got %b%b required %b%b",
                   k, n, oa, ob, m_bcomb(k, raa), m_bcomb(k, rab));
        end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        logic [7:0] ga, gb, gv;
        ga = (k == 0) ? rda0 : rda1;
        gb = (k == 0) ? rdb0 : rdb1;
        gv = (k == 0) ? bv0 : bv1;
        checks++;
        if (ga !== m_rda[k] || gb !== m_rdb[k] || gv !== m_busy[k]) begin
          failures++;
          $display("FAIL rand_regs[%0d] n=%0d: a=%h b=%h bv=%h required %h %h %h",
                   k, n, ga, gb, gv, m_rda[k], m_rdb[k], m_busy[k]);
        end
      end
    end
    idle();
  endtask

  task automatic test_width();
    w_we = 1'b1; w_wa = 4'd15; w_wd = 16'hBEEF; w_rsv = 1'b1; w_rsa = 4'd15;
    @(posedge clk);
    @(negedge clk);
    w_we = 1'b0; w_rsv = 1'b0; w_re = 1'b1; w_raa = 4'd15; w_rab = 4'd15;
    #1;
    checks++;
    if (ba2 !== 1'b1 || bv2 !== 16'h8000) begin
      failures++;
      $display("FAIL wide_busy: busy_a=%b bv=%h required 1 8000", ba2, bv2);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rda2 !== 16'hBEEF || rdb2 !== 16'hBEEF) begin
      failures++;
      $display("FAIL wide_read: a=%h b=%h required beef beef", rda2, rdb2);
    end
    w_re = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    w_we = 1'b0; w_re = 1'b0; w_rsv = 1'b0;
    w_wa = 4'd0; w_wd = 16'h0; w_raa = 4'd0; w_rab = 4'd0; w_rsa = 4'd0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic();
    test_forward();
    test_zero_reg();
    test_scoreboard();
    test_simultaneous();
    test_random();
    test_width();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_bank_2r1w.md
Name: register_bank_2r1w

Overview:
Parametrised successor to the 8x8 single-read register bank: a 2^ADDR_W x DATA_W register file with two registered read ports, one write port, write-to-read forwarding, optional hardwired-zero register 0, and a per-register busy scoreboard. It is the operand store for the pipelined datapath. Reads have one-cycle latency so they align with the decode/execute pipeline register. The scoreboard lets the issue stage detect read-after-write hazards.

Parameters:
DATA_W, 8, register width in bits
ADDR_W, 3, address width; depth = 2^ADDR_W registers
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and ignores reservations; 0 = register 0 is ordinary

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  asynchronous, active-high reset
we  input  1  write enable
write_addr  input  ADDR_W  write address
write_data  input  DATA_W  write data
re  input  1  read enable, both ports
read_addr_a  input  ADDR_W  port A read address
read_addr_b  input  ADDR_W  port B read address
read_data_a  output  DATA_W  port A data, registered
read_data_b  output  DATA_W  port B data, registered
rsv_en  input  1  reserve request: mark rsv_addr busy
rsv_addr  input  ADDR_W  register to reserve
busy_a  output  1  combinational busy flag for read_addr_a
busy_b  output  1  combinational busy flag for read_addr_b
busy_vec  output  2^ADDR_W  registered busy bit per register

Behaviour:
- Reset (async, rst=1): all registers = 0; read_data_a = read_data_b = 0; busy_vec = 0. Held while rst=1. Reset mid-operation discards any in-flight write or reservation. The first edge after rst falls behaves normally.
- Blocked write: the write is blocked when ZERO_REG=1 and write_addr=0. A blocked write has no effect anywhere, including forwarding and busy clearing.
- Write: at posedge with we=1 and the write not blocked, registers[write_addr] <= write_data.
- Read, 1-cycle latency: at posedge with re=1, each port loads its value from the sources below, in priority order.
  - 0, if ZERO_REG=1 and the port address = 0.
  - write_data, if we=1, the write is not blocked, and write_addr = the port address. This is write-first forwarding.
  - Otherwise, registers[port address] as it was before the edge.
- re=0: read_data_a and read_data_b hold their previous values.
- Both ports may use the same address; each resolves independently.
- Scoreboard at posedge, per register i:
  - busy[i] <= 1 if rsv_en=1, rsv_addr=i, and not (ZERO_REG=1 and i=0).
  - Otherwise busy[i] <= 0 if an unblocked write targets i.
  - Otherwise busy[i] holds.
- Simultaneous reserve and write to the same register: the reservation wins and busy stays 1 (a newer producer is outstanding). The data write still happens.
- busy_a = busy[read_addr_a] AND NOT (we=1 AND write not blocked AND write_addr=read_addr_a). busy_b is defined the same way for port B. A same-cycle write therefore clears the hazard because the value is forwarded.
- With ZERO_REG=1, busy[0] is constant 0.
- Address range is exactly 2^ADDR_W, so no out-of-range case exists. All address arithmetic is unsigned.

Test Plan:
- Reset: rst=1 mid-write (we=1, addr 5, 0xAA); release; re=1 on addr 5 -> read_data=0x00 next cycle, busy_vec=0.
- Basic write/read: write 0x3C to r2; next cycle re=1 with A=2, B=2 -> both ports 0x3C one cycle later. With re=0 on the following cycle, the outputs hold 0x3C.
- Forwarding: same cycle we=1 r4=0x5A, re=1 A=4, B=3 (r3=0x11) -> A=0x5A, B=0x11 after the edge. r4 reads 0x5A afterwards.
- Zero register (ZERO_REG=1): write 0xFF to r0, rsv_en to r0 -> r0 reads 0x00, busy_vec[0]=0. With ZERO_REG=0 the same sequence gives r0=0xFF and busy_vec[0]=1.
- Scoreboard, reserve then write:
  - rsv r6 -> busy_vec[6]=1, busy_a=1 with A=6.
  - Cycle with we=1 to r6 -> busy_a=0 combinationally, busy_vec[6]=0 after the edge.
- Scoreboard, simultaneous events: rsv_en and we to r6 in the same cycle -> busy_vec[6]=1 and r6 = new data.
- Width sweep: DATA_W=16, ADDR_W=4 -> write 0xBEEF to r15, read 0xBEEF; busy_vec is 16 bits wide.
